mpq_cmd_issuer: RTL and testbench

MPQ_CMD_ISSUER -- requirements
Module: mpq_cmd_issuer

---
 rtl/mpq_pkg.sv | 25 ++
 rtl/mpq_cmd_fifo.sv | 62 ++++++
 rtl/mpq_cmd_issuer.sv | 139 +++++++++++++
 tb/tb_mpq_cmd_issuer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpq_pkg.sv
// Shared definitions for the MPQ command issuer: command codes, FSM encoding
// and the packed command entry carried through the FIFO.
package mpq_pkg;

    localparam int unsigned ENTRY_W = 19;
    localparam int unsigned DATA_W  = 8;

    localparam logic [2:0] MPQ_BUILD    = 3'd0;
    localparam logic [2:0] MPQ_EXTRACT  = 3'd1;
    localparam logic [2:0] MPQ_INCREASE = 3'd2;
    localparam logic [2:0] MPQ_INSERT   = 3'd3;
    localparam logic [2:0] MPQ_WRITE    = 3'd4;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [DATA_W-1:0] index;
        logic [DATA_W-1:0] value;
    } cmd_entry_t;

endpackage

// File: rtl/mpq_cmd_fifo.sv
// Command FIFO: power-of-2 depth, wrapping pointers, occupancy count 0..DEPTH.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mpq_cmd_fifo
    import mpq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  cmd_entry_t               push_data_i,
    input  logic                     pop_i,
    output cmd_entry_t               pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mpq_cmd_issuer.sv
// Sequences an MPQ session: forwards host data in LOAD, then issues queued
// commands one at a time until CMD_WRITE is issued and the MPQ reports done.
module mpq_cmd_issuer
    import mpq_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [2:0]  CMD_WRITE = MPQ_WRITE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_data_valid,
    input  logic [7:0] in_data,
    input  logic       in_cmd_valid,
    input  logic [2:0] in_cmd,
    input  logic [7:0] in_index,
    input  logic [7:0] in_value,
    output logic       in_ready,
    input  logic       busy,
    input  logic       mpq_done,
    output logic       data_valid,
    output logic [7:0] data,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [7:0] index,
    output logic [7:0] value,
    output logic [7:0] data_cnt,
    output logic       ovf,
    output logic       seq_err
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [7:0]  CNT_MAX = 8'hFF;

    logic [1:0]  state_q,      state_d;
    logic        data_valid_q, data_valid_d;
    logic [7:0]  data_q,       data_d;
    logic [7:0]  data_cnt_q,   data_cnt_d;
    logic        cmd_valid_q,  cmd_valid_d;
    cmd_entry_t  cmd_ent_q,    cmd_ent_d;
    logic        ovf_q,        ovf_d;
    logic        seq_err_q,    seq_err_d;

    cmd_entry_t  push_ent, head_ent;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign push_ent  = cmd_entry_t'{cmd: in_cmd, index: in_index, value: in_value};
    assign in_ready  = (fifo_count != CW'(DEPTH));
    assign fifo_push = in_cmd_valid & in_ready;

    mpq_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_ent),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_ent),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Next-state and registered-output values; idle outputs are forced to zero.
    always_comb begin
        state_d      = state_q;
        data_valid_d = 1'b0;
        data_d       = '0;
        data_cnt_d   = data_cnt_q;
        cmd_valid_d  = 1'b0;
        cmd_ent_d    = '0;
        fifo_pop     = 1'b0;
        ovf_d        = ovf_q | (in_cmd_valid & fifo_full);
        seq_err_d    = seq_err_q | (in_data_valid & (state_q != ST_LOAD));

        case (state_q)
            ST_LOAD: begin
                if (in_data_valid) begin
                    data_valid_d = 1'b1;
                    data_d       = in_data;
                    if (data_cnt_q != CNT_MAX) data_cnt_d = data_cnt_q + 8'd1;
                end else if (data_cnt_q != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!fifo_empty && !busy) begin
                    fifo_pop    = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_ent_d   = head_ent;
                    state_d     = ST_HOLD;
                end
            end
            // cmd_ent_q still holds the command issued on entry to HOLD.
            ST_HOLD: begin
                state_d = (cmd_ent_q.cmd == CMD_WRITE) ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                if (mpq_done) begin
                    state_d    = ST_LOAD;
                    data_cnt_d = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            data_cnt_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_ent_q    <= '0;
            ovf_q        <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            data_cnt_q   <= data_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_ent_q    <= cmd_ent_d;
            ovf_q        <= ovf_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign data_cnt   = data_cnt_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd        = cmd_ent_q.cmd;
    assign index      = cmd_ent_q.index;
    assign value      = cmd_ent_q.value;
    assign ovf        = ovf_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_mpq_cmd_issuer.sv
// Bench for mpq_cmd_issuer: directed session scenarios followed by random
// traffic, all compared every cycle against a queue-based session model.
module tb_mpq_cmd_issuer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_data_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_cmd_valid = 1'b0;
    logic [2:0] in_cmd = 3'd0;
    logic [7:0] in_index = 8'd0;
    logic [7:0] in_value = 8'd0;
    logic       busy = 1'b0;
    logic       mpq_done = 1'b0;
    logic       in_ready, data_valid, cmd_valid, ovf, seq_err;
    logic [7:0] data, index, value, data_cnt;
    logic [2:0] cmd;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    mpq_cmd_issuer #(.DEPTH(DEPTH), .CMD_WRITE(3'd4)) dut (
        .clk(clk), .rst(rst),
        .in_data_valid(in_data_valid), .in_data(in_data),
        .in_cmd_valid(in_cmd_valid), .in_cmd(in_cmd),
        .in_index(in_index), .in_value(in_value),
        .in_ready(in_ready), .busy(busy), .mpq_done(mpq_done),
        .data_valid(data_valid), .data(data),
        .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
        .data_cnt(data_cnt), .ovf(ovf), .seq_err(seq_err)
    );

    // Session model: a phase name, a command queue and the expected outputs.
    typedef enum int {M_LOAD, M_ISSUE, M_HOLD, M_FINISH} mode_t;
    typedef struct packed { logic [2:0] c; logic [7:0] i; logic [7:0] v; } ent_t;

    ent_t       q[$];
    mode_t      mode = M_LOAD;
    logic [2:0] last_cmd = 3'd0;
    int         m_cnt = 0;
    bit         e_dv = 0, e_cv = 0, e_ovf = 0, e_seq = 0, e_rdy = 1;
    logic [7:0] e_data = 0, e_idx = 0, e_val = 0;
    logic [2:0] e_cmd = 0;

    task automatic model_step();
        ent_t head;
        bit   room;
        if (rst) begin
            q.delete();
            mode = M_LOAD; m_cnt = 0;
            e_dv = 0; e_data = 0; e_cv = 0; e_cmd = 0; e_idx = 0; e_val = 0;
            e_ovf = 0; e_seq = 0; e_rdy = 1;
        end else begin
            room = (q.size() < DEPTH);
            if (in_cmd_valid && !room) e_ovf = 1;
            if (in_data_valid && mode != M_LOAD) e_seq = 1;
            e_dv = 0; e_data = 0; e_cv = 0; e_cmd = 0; e_idx = 0; e_val = 0;
            case (mode)
                M_LOAD:
                    if (in_data_valid) begin
                        e_dv = 1; e_data = in_data;
                        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    end else if (m_cnt > 0) mode = M_ISSUE;
                M_ISSUE:
                    if (q.size() > 0 && !busy) begin
                        head = q.pop_front();
                        e_cv = 1; e_cmd = head.c; e_idx = head.i; e_val = head.v;
                        last_cmd = head.c;
                        mode = M_HOLD;
                    end
                M_HOLD:
                    mode = (last_cmd == 3'd4) ? M_FINISH : M_ISSUE;
                default:
                    if (mpq_done) begin mode = M_LOAD; m_cnt = 0; end
            endcase
            if (in_cmd_valid && room) q.push_back(ent_t'{c: in_cmd, i: in_index, v: in_value});
            e_rdy = (q.size() < DEPTH);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, away from the active edge, compare all outputs to the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready",   32'(in_ready),   32'(e_rdy));
            chk("data_valid", 32'(data_valid), 32'(e_dv));
            chk("data",       32'(data),       32'(e_data));
            chk("data_cnt",   32'(data_cnt),   32'(m_cnt));
            chk("cmd_valid",  32'(cmd_valid),  32'(e_cv));
            chk("cmd",        32'(cmd),        32'(e_cmd));
            chk("index",      32'(index),      32'(e_idx));
            chk("value",      32'(value),      32'(e_val));
            chk("ovf",        32'(ovf),        32'(e_ovf));
            chk("seq_err",    32'(seq_err),    32'(e_seq));
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle();
        in_data_valid = 0; in_cmd_valid = 0; mpq_done = 0;
    endtask

    task automatic push(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
        in_cmd_valid = 1; in_cmd = c; in_index = i; in_value = v;
    endtask

    initial begin
        int n_iss;
        step();
        check_en = 1;
        step();
        rst = 0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_cv",    32'(cmd_valid), 32'd0);
        chk("rst_cnt",   32'(data_cnt), 32'd0);

        // 12 data words with three commands queued along the way.
        for (int i = 0; i < 12; i++) begin
            in_data_valid = 1; in_data = 8'(8'h11 + i);
            if (i < 3) push(3'(i + 1), 8'(8'h20 + i), 8'(8'h40 + i));
            else in_cmd_valid = 0;
            step();
            chk("load_dv",   32'(data_valid), 32'd1);
            chk("load_data", 32'(data), 32'(8'h11 + i));
        end
        chk("cnt12",       32'(data_cnt), 32'd12);
        chk("model_cnt12", 32'(m_cnt), 32'd12);
        idle();
        step();
        chk("exit_cv", 32'(cmd_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("iss_cv",  32'(cmd_valid), 32'd1);
            chk("iss_cmd", 32'(cmd), 32'(k + 1));
            chk("iss_idx", 32'(index), 32'(8'h20 + k));
            step();
            chk("gap_cv",  32'(cmd_valid), 32'd0);
        end

        // busy held for 10 cycles with one command pending.
        busy = 1; push(3'd2, 8'h33, 8'h44);
        step();
        idle();
        chk("busy_cv", 32'(cmd_valid), 32'd0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("busy_cv", 32'(cmd_valid), 32'd0);
        end
        busy = 0;
        step();
        chk("unbusy_cv",  32'(cmd_valid), 32'd1);
        chk("unbusy_cmd", 32'(cmd), 32'd2);
        step();

        // Nine pushes with no pops: the ninth overflows.
        busy = 1;
        for (int i = 0; i < 9; i++) begin
            push(3'(i % 4), 8'(i), 8'(8'h80 + i));
            step();
        end
        idle();
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_ovf",   32'(ovf), 32'd1);
        busy = 0;
        n_iss = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (cmd_valid) n_iss++;
        end
        chk("drain_count", 32'(n_iss), 32'd8);
        chk("ovf_sticky",  32'(ovf), 32'd1);

        // WRITE ends issuing until mpq_done; stray data sets seq_err.
        push(3'd4, 8'hAA, 8'h55);
        step();
        push(3'd1, 8'h01, 8'h02);
        step();
        chk("wr_cv",  32'(cmd_valid), 32'd1);
        chk("wr_cmd", 32'(cmd), 32'd4);
        chk("wr_idx", 32'(index), 32'hAA);
        push(3'd2, 8'h03, 8'h04);
        step();
        idle();
        in_data_valid = 1; in_data = 8'h99;
        for (int k = 0; k < 6; k++) begin
            step();
            in_data_valid = 0;
            chk("fin_cv", 32'(cmd_valid), 32'd0);
            chk("fin_dv", 32'(data_valid), 32'd0);
        end
        chk("seq_err", 32'(seq_err), 32'd1);
        mpq_done = 1;
        step();
        mpq_done = 0;
        chk("done_cnt",     32'(data_cnt), 32'd0);
        chk("model_q2",     32'(q.size()), 32'd2);

        // Reset mid-ISSUE with four queued commands.
        in_data_valid = 1; in_data = 8'h01; push(3'd3, 8'h05, 8'h06);
        step();
        in_data = 8'h02; push(3'd0, 8'h07, 8'h08);
        step();
        idle(); busy = 1;
        step();
        step();
        chk("pre_rst_cv", 32'(cmd_valid), 32'd0);
        chk("model_q4",   32'(q.size()), 32'd4);
        rst = 1;
        step();
        rst = 0; busy = 0;
        chk("rst2_ready", 32'(in_ready), 32'd1);
        chk("rst2_cv",    32'(cmd_valid), 32'd0);
        chk("rst2_ovf",   32'(ovf), 32'd0);
        chk("rst2_seq",   32'(seq_err), 32'd0);
        step();
        chk("post_rst_cv", 32'(cmd_valid), 32'd0);
        chk("model_q0",    32'(q.size()), 32'd0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 399) == 0);
            in_data_valid = ($urandom_range(0, 2) == 0);
            in_data       = 8'($urandom);
            in_cmd_valid  = ($urandom_range(0, 1) == 0);
            in_cmd        = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            in_index      = 8'($urandom);
            in_value      = 8'($urandom);
            busy          = ($urandom_range(0, 3) == 0);
            mpq_done      = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 0; idle(); busy = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
